// File: rtl/ifsram_stream_out_if.sv
// Stream port toward the downstream FIFO: data word, not-full flag and write strobe.
// The master drives data/write and watches full_n; the slave is the FIFO side.
interface ifsram_stream_out_if #(
    parameter int TBITS = 64
) ();
    logic [TBITS-1:0] out_data_dout;
    logic             out_full_n_din;
    logic             out_write_dout;

    modport master (
        output out_data_dout,
        output out_write_dout,
        input  out_full_n_din
    );

    modport slave (
        input  out_data_dout,
        input  out_write_dout,
        output out_full_n_din
    );
endinterface

// File: rtl/ifsram_stream_out.sv
// Reads a run of words from one ping-pong IF_SRAM bank and streams them to a FIFO.
// A small credit-limited buffer absorbs the one-cycle SRAM read latency and downstream stalls.
module ifsram_stream_out #(
    parameter int TBITS      = 64,
    parameter int ADDR_BITS  = 11,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 bank_sel,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   word_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 cen_b0,
    output logic                 cen_b1,
    output logic [ADDR_BITS-1:0] addr_b,
    input  logic [TBITS-1:0]     q_b0,
    input  logic [TBITS-1:0]     q_b1,
    ifsram_stream_out_if.master  out_if
);

    localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [OCC_W-1:0]     OCC_ZERO  = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0]     OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0]     OCC_FULL  = OCC_W'(OBUF_DEPTH);
    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   CNT_ZERO  = {(ADDR_BITS+1){1'b0}};
    localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);
    localparam logic [TBITS-1:0]     DATA_ZERO = {TBITS{1'b0}};

    logic [1:0]           state_q, state_d;
    logic                 bank_q, bank_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_BITS:0]   rem_q, rem_d;
    logic                 inflight_q;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [TBITS-1:0]     buf_q [OBUF_DEPTH];
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 credit_ok_s;
    logic                 issue_s;
    logic                 push_s;
    logic                 pop_s;
    logic [TBITS-1:0]     push_data_s;

    // Credit counts words buffered plus the read in flight; a pop this cycle is not credited.
    assign credit_ok_s = (occ_q + {{(OCC_W-1){1'b0}}, inflight_q}) < OCC_FULL;
    assign issue_s     = (state_q == ST_READ) && (rem_q != CNT_ZERO) && credit_ok_s;
    assign push_s      = inflight_q;
    assign push_data_s = bank_q ? q_b1 : q_b0;
    assign pop_s       = (occ_q != OCC_ZERO) && out_if.out_full_n_din;

    assign cen_b0 = ~(issue_s & ~bank_q);
    assign cen_b1 = ~(issue_s & bank_q);
    assign addr_b = rd_addr_q;

    assign out_if.out_write_dout = pop_s;
    assign out_if.out_data_dout  = buf_q[rd_ptr_q];

    assign busy = busy_q;
    assign done = done_q;

    // Run-control FSM next state and read-address/remaining-count bookkeeping.
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        rd_addr_d = rd_addr_q;
        rem_d     = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bank_d    = bank_sel;
                    rd_addr_d = base_addr;
                    rem_d     = word_cnt;
                    if (word_cnt != CNT_ZERO) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                    rem_d     = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (occ_q == OCC_ZERO)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Buffer occupancy update for simultaneous push/pop.
    always_comb begin
        occ_d = occ_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Status flags: busy tracks the run states; done is reported the cycle after FIN.
    always_comb begin
        busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d = (state_q == ST_FIN);
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bank_q     <= 1'b0;
            rd_addr_q  <= ADDR_ZERO;
            rem_q      <= CNT_ZERO;
            inflight_q <= 1'b0;
            occ_q      <= OCC_ZERO;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            rd_addr_q  <= rd_addr_d;
            rem_q      <= rem_d;
            inflight_q <= issue_s;
            occ_q      <= occ_d;
            wr_ptr_q   <= push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_q   <= pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Output buffer storage; the SRAM word arrives the cycle after its read was issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                buf_q[i] <= DATA_ZERO;
            end
        end else if (push_s) begin
            buf_q[wr_ptr_q] <= push_data_s;
        end else begin
            buf_q[wr_ptr_q] <= buf_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_ifsram_stream_out.sv
// Directed and randomized runs of ifsram_stream_out against bank memories and an
// address-order / credit-bound reference kept in the bench.
module tb_ifsram_stream_out;
    localparam int TBITS = 64;
    localparam int AB    = 11;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          bank_sel;
    logic [AB-1:0] base_addr;
    logic [AB:0]   word_cnt;
    logic          busy, done, cen_b0, cen_b1;
    logic [AB-1:0] addr_b;
    logic [63:0]   q_b0, q_b1;

    ifsram_stream_out_if #(.TBITS(TBITS)) out_if ();

    ifsram_stream_out #(.TBITS(TBITS), .ADDR_BITS(AB), .OBUF_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bank_sel  (bank_sel),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .busy      (busy),
        .done      (done),
        .cen_b0    (cen_b0),
        .cen_b1    (cen_b1),
        .addr_b    (addr_b),
        .q_b0      (q_b0),
        .q_b1      (q_b1),
        .out_if    (out_if.master)
    );

    logic [63:0] mem0 [2048];
    logic [63:0] mem1 [2048];

    // Bank read model: Q reflects the addressed word the cycle after CEN low.
    always @(posedge clk) begin
        if (!cen_b0) q_b0 <= mem0[addr_b];
        if (!cen_b1) q_b1 <= mem1[addr_b];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit active = 1'b0;
    bit run_bank;
    int run_base, run_cnt, issued, writes, dones;
    int start_cyc, first_iss_cyc, first_wr_cyc, last_wr_cyc, done_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic          sel_cen, unsel_cen;
        logic [AB-1:0] ea;
        sel_cen   = run_bank ? cen_b1 : cen_b0;
        unsel_cen = run_bank ? cen_b0 : cen_b1;
        if (out_if.out_write_dout) chk("no_write_when_full", 64'(out_if.out_full_n_din), 64'd1);
        if (!active) begin
            chk("idle_cen", 64'({cen_b1, cen_b0}), 64'd3);
            chk("idle_write", 64'(out_if.out_write_dout), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
        end else begin
            chk("unsel_cen_high", 64'(unsel_cen), 64'd1);
            if (!sel_cen) begin
                ea = AB'(run_base + issued);
                chk("rd_addr", 64'(addr_b), 64'(ea));
                chk("credit_bound", 64'((issued + 1 - writes) <= DEPTH), 64'd1);
                chk("no_over_issue", 64'(issued < run_cnt), 64'd1);
                if (issued == 0) first_iss_cyc = cyc;
                issued++;
            end
            if (out_if.out_write_dout) begin
                ea = AB'(run_base + writes);
                chk("wr_data", out_if.out_data_dout, run_bank ? mem1[ea] : mem0[ea]);
                if (writes == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                writes++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                chk("done_after_all_writes", 64'(writes), 64'(run_cnt));
                chk("busy_low_at_done", 64'(busy), 64'd0);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_cen"}, 64'({cen_b1, cen_b0}), 64'd3);
        chk({tag, "_addr"}, 64'(addr_b), 64'd0);
        chk({tag, "_write"}, 64'(out_if.out_write_dout), 64'd0);
        chk({tag, "_data"}, out_if.out_data_dout, 64'd0);
    endtask

    function automatic logic full_n_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 2) == 0;
            2:       return $urandom_range(0, 3) != 0;
            3:       return k >= 20;
            default: return 1'b1;
        endcase
    endfunction

    task automatic begin_run(input bit bank, input int base, input int cnt, input int mode);
        run_bank = bank; run_base = base; run_cnt = cnt;
        issued = 0; writes = 0; dones = 0;
        first_iss_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
        active = 1'b1;
        bank_sel  = bank;
        base_addr = AB'(base);
        word_cnt  = (AB+1)'(cnt);
        start     = 1'b1;
        out_if.out_full_n_din = full_n_for(mode, 0);
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_xfer(input bit bank, input int base, input int cnt, input int mode);
        int k;
        begin_run(bank, base, cnt, mode);
        k = 1;
        while (dones == 0 && k < 8 * cnt + 60) begin
            out_if.out_full_n_din = full_n_for(mode, k);
            if (k == 1 && cnt > 0) chk("busy_in_run", 64'(busy), 64'd1);
            if (mode == 3 && k == 20) chk("stall_issue_count", 64'(issued), 64'd4);
            tick();
            k++;
        end
        out_if.out_full_n_din = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        active = 1'b0;
        chk("done_once", 64'(dones), 64'd1);
        chk("total_writes", 64'(writes), 64'(cnt));
        chk("total_issues", 64'(issued), 64'(cnt));
        if (cnt == 0) begin
            chk("zero_cnt_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        end else begin
            chk("done_after_last_write", 64'(done_cyc > last_wr_cyc), 64'd1);
            chk("first_issue_lat", 64'(first_iss_cyc - start_cyc), 64'd1);
            if (mode == 0) begin
                chk("first_write_lat", 64'(first_wr_cyc - start_cyc), 64'd3);
                chk("back_to_back", 64'(last_wr_cyc - first_wr_cyc), 64'(cnt - 1));
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bank_sel = 1'b0;
        base_addr = '0; word_cnt = '0;
        out_if.out_full_n_din = 1'b1;
        for (int k = 0; k < 2048; k++) begin
            mem0[k] = 64'(k);
            mem1[k] = {$urandom, $urandom};
        end
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) tick();

        run_xfer(1'b0, 0, 16, 0);
        run_xfer(1'b0, 0, 16, 1);
        run_xfer(1'b0, 0, 16, 3);
        run_xfer(1'b1, 2046, 4, 0);
        run_xfer(1'b0, 100, 0, 0);
        run_xfer(1'b1, int'($urandom_range(0, 2047)), 2048, 0);
        for (int r = 0; r < 4; r++) begin
            run_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)),
                     int'($urandom_range(1, 64)), 2);
        end

        // Abort a long run with reset and confirm the engine goes quiet.
        begin_run(1'b0, 5, 100, 0);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        active = 1'b0;
        @(negedge clk);
        check_reset_vals("midrun_reset");
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 20; i++) tick();
        run_xfer(1'b1, 7, 16, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
